// File: rtl/esp32_boot_sequencer.sv
// esp32_boot_sequencer: drives the ESP32 EN pin and the boot strap pins through
// a reset-and-strap sequence. wifi_en is held low for C_en_low_cycles clocks,
// then released while the straps stay driven for C_strap_hold_cycles clocks,
// and the sequence finishes with a one-cycle done pulse. All outputs come
// straight from flops.
module esp32_boot_sequencer #(
    parameter int unsigned C_en_low_cycles     = 2500000,
    parameter int unsigned C_strap_hold_cycles = 1250000
) (
    input  logic clk_25mhz,
    input  logic reset,
    input  logic req,
    input  logic boot_mode,
    output logic busy,
    output logic done,
    output logic wifi_en,
    output logic strap_oe,
    output logic gpio0_o,
    output logic gpio2_o,
    output logic gpio4_o,
    output logic gpio12_o,
    output logic gpio13_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EN_LOW     = 2'd1,
        STRAP_HOLD = 2'd2,
        DONE       = 2'd3
    } state_t;

    // Each timed state is entered with (length - 1) loaded. The state is left
    // on the edge where the count is already zero, so it lasts exactly
    // 'length' clocks.
    localparam logic [23:0] EN_LOAD   = 24'(C_en_low_cycles - 1);
    localparam logic [23:0] HOLD_LOAD = 24'(C_strap_hold_cycles - 1);

    state_t      state;
    state_t      state_nxt;
    logic        mode_q;
    logic        mode_nxt;
    logic [23:0] cnt;
    logic [23:0] cnt_nxt;

    logic busy_nxt;
    logic done_nxt;
    logic wifi_en_nxt;
    logic strap_oe_nxt;
    logic gpio02_nxt;

    // Next-state, counter and next-output decode. Outputs are decoded from
    // the next state so that the registered outputs line up with the state
    // register.
    always_comb begin
        // NOTE: every signal gets a default before the case statement.
        // A path that leaves a signal unassigned would infer a latch.
        state_nxt    = state;
        mode_nxt     = mode_q;
        cnt_nxt      = cnt;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        wifi_en_nxt  = 1'b1;
        strap_oe_nxt = 1'b0;
        gpio02_nxt   = 1'b1;

        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = EN_LOW;
                    mode_nxt  = boot_mode;
                    cnt_nxt   = EN_LOAD;
                end
            end
            EN_LOW: begin
                if (cnt == 24'd0) begin
                    state_nxt = STRAP_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    cnt_nxt = cnt - 24'd1;
                end
            end
            STRAP_HOLD: begin
                if (cnt == 24'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 24'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 24'd0;
            end
        endcase

        case (state_nxt)
            EN_LOW: begin
                busy_nxt     = 1'b1;
                wifi_en_nxt  = 1'b0;
                strap_oe_nxt = 1'b1;
                gpio02_nxt   = ~mode_nxt;
            end
            STRAP_HOLD: begin
                busy_nxt     = 1'b1;
                strap_oe_nxt = 1'b1;
                gpio02_nxt   = ~mode_nxt;
            end
            DONE: begin
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and output registers. Reset wins over req and aborts
    // any sequence in progress, releasing the straps on the same edge.
    always_ff @(posedge clk_25mhz) begin
        // NOTE: sequential state is assigned with non-blocking '<=' only, so
        // every flop samples values from before the edge.
        if (reset) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            cnt      <= 24'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wifi_en  <= 1'b1;
            strap_oe <= 1'b0;
            gpio0_o  <= 1'b1;
            gpio2_o  <= 1'b1;
        end else begin
            state    <= state_nxt;
            mode_q   <= mode_nxt;
            cnt      <= cnt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            wifi_en  <= wifi_en_nxt;
            strap_oe <= strap_oe_nxt;
            gpio0_o  <= gpio02_nxt;
            gpio2_o  <= gpio02_nxt;
        end
    end

    // These straps have the same value in both boot modes and whether or not
    // they are driven, so they are tied to constants.
    assign gpio4_o  = 1'b1;
    assign gpio12_o = 1'b0;
    assign gpio13_o = 1'b1;

endmodule
